mem_byte_master: RTL
====================

# mem_byte_master

Memory-stage initiator for the ARM pipeline. Takes one word-wide MEMread/MEMwrite request from the MEM stage and performs it as four sequential byte transactions on a byte-wide request/acknowledge bus that fronts the byte-organised data memory. It holds the pipeline with `freeze` until the word is complete, then presents the assembled read word on `MEMresult`.

## Interface
- `BASE`, 1024: byte address mapped to memory offset 0
- `DEPTH`, 64: memory size in bytes (multiple of 4)
- `clk` in 1: the only clock; all logic on rising edge
- `rst` in 1: reset, synchronous and active-high
- `MEMread` in 1: word read request from MEM stage
- `MEMwrite` in 1: word write request from MEM stage
- `address` in 32: byte address; bits [1:0] ignored
- `data` in 32: write word
- `MEMresult` out 32: assembled read word
- `freeze` out 1: pipeline stall
- `err` out 1: out-of-range access flag
- `byte_req` out 1: byte transaction valid
- `byte_we` out 1: 1 = byte write, 0 = byte read
- `byte_addr` out 32: memory byte offset
- `byte_wdata` out 8: write byte
- `byte_rdata` in 8: read byte, valid when `byte_ack` is high
- `byte_ack` in 1: responder completes the current byte

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE with `MEMread|MEMwrite` high:
  - latch `off = {address[31:2],2'b00} - BASE`, `data`, and op
  - write wins if both request lines are high
  - clear byte counter `k` and go to ACCESS
  - if `off + 3 >= DEPTH` (unsigned, including wrap below BASE), go directly to DONE with `err` set and no byte transactions
- ACCESS:
  - `byte_req` high; `byte_addr = off + k`; `byte_we` = latched op
  - `byte_wdata` = latched word byte k, big-endian: k=0 is [31:24], k=3 is [7:0]
  - outputs stay stable until `byte_ack` is sampled high
  - on ack, a read shifts `byte_rdata` into the result register (k=0 lands in [31:24]) and `k` increments
  - ack with k=3 goes to DONE
- DONE: one cycle, then IDLE.
- `MEMresult` holds the last completed read word until the next read finishes. A write or an `err` access leaves it unchanged, except that an `err` read loads 0.
- `err` is high only in DONE.
- `byte_ack` is ignored outside ACCESS.

## Timing
- Reset values: state IDLE, `k`=0, `MEMresult`=0, `freeze`=0, `err`=0, `byte_req`=0, `byte_we`=0, `byte_addr`=0, `byte_wdata`=0.
- `freeze` (combinational) = `(IDLE & (MEMread|MEMwrite)) | ACCESS`. It is low in DONE so the pipeline advances in that cycle.
- With `byte_ack` tied high, a request at cycle 0 produces:
  - bytes in cycles 1–4
  - DONE in cycle 5, with `MEMresult` valid and `freeze` low
  - `freeze` high for 5 cycles
- Each acknowledge wait state adds one cycle.
- Out-of-range access: `freeze` high 1 cycle, DONE next cycle.
- `rst` during ACCESS: next edge returns to IDLE and drops `byte_req`. A partial write is not rolled back.
- A request present during DONE is ignored. The pipeline has advanced, so the request seen in IDLE the following cycle is the new one.

## Structure
- Shared package `mem_pkg` holds:
  - state enum (IDLE/ACCESS/DONE)
  - `BASE`/`DEPTH` defaults
  - byte-lane select function (k → word slice)
- One sub-module: `word_assembler`, a 4-byte shift register with load-on-ack and clear.
- The FSM, counter and range check stay in `mem_byte_master`.

## Test plan
- Reset, then `MEMread` at 0x400 with memory bytes 11,22,33,44 and ack tied high → four reads at offsets 0..3; DONE in cycle 5 with `MEMresult`=0x11223344; `freeze` high exactly 5 cycles.
- `MEMwrite` 0xDEADBEEF at 0x407 (misaligned) → writes DE,AD,BE,EF to offsets 4..7.
- Ack delayed 2 cycles on byte 2 → `byte_addr`/`byte_wdata` stable throughout the wait; `freeze` lasts 7 cycles.
- `MEMread` at 0x43C → valid, offsets 60..63. `MEMread` at 0x440 and at 0x3FC → no `byte_req`, `err` high one cycle, `MEMresult`=0.
- `MEMread` and `MEMwrite` both high → write performed; `MEMresult` unchanged.
- `rst` asserted after the second ack → `byte_req`=0 and all outputs at reset values next cycle; a following read completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type, default memory window (BASE_DEFAULT, DEPTH_DEFAULT) and the big-endian byte-lane select
package mem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  localparam int unsigned BASE_DEFAULT = 1024;
  localparam int unsigned DEPTH_DEFAULT = 64;
  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] k);
    return w[31-8*k -: 8];
  endfunction
endpackage

// File: rtl/mem_byte_master_if.sv
// mem_byte_master_if: byte bus; master drives byte_req/byte_we/byte_addr/byte_wdata, slave returns byte_rdata/byte_ack
interface mem_byte_master_if;
  logic byte_req;
  logic byte_we;
  logic [31:0] byte_addr;
  logic [7:0] byte_wdata;
  logic [7:0] byte_rdata;
  logic byte_ack;
  modport master(output byte_req, byte_we, byte_addr, byte_wdata, input byte_rdata, byte_ack);
  modport slave(input byte_req, byte_we, byte_addr, byte_wdata, output byte_rdata, byte_ack);
endinterface

// File: rtl/mem_byte_master_word_assembler.sv
// word_assembler: byte shift register (clk, rst, clr, load, byte_i); word_o is the held bytes followed by byte_i
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o
);
  logic [23:0] sh_q;
  assign word_o = {sh_q, byte_i};
  always_ff @(posedge clk)
    if (rst || clr) sh_q <= '0;
    else if (load) sh_q <= {sh_q[15:0], byte_i};
endmodule

// File: rtl/mem_byte_master.sv
// mem_byte_master: word MEMread/MEMwrite (address, data) -> four byte transactions on bus; freeze stalls, MEMresult/err report
module mem_byte_master
  import mem_pkg::*;
#(
  parameter int unsigned BASE  = BASE_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MEMread,
  input  logic                     MEMwrite,
  input  logic [31:0]              address,
  input  logic [31:0]              data,
  output logic [31:0]              MEMresult,
  output logic                     freeze,
  output logic                     err,
  mem_byte_master_if.master        bus
);
  state_e      state_q;
  logic [1:0]  k_q;
  logic [31:0] wdat_q, res_q, baddr_q, off_d, asm_word;
  logic [7:0]  bwd_q;
  logic        err_q, req_q, bwe_q, mem_req, oor, hit;
  assign mem_req = MEMread | MEMwrite;
  assign off_d = (address & ~32'd3) - BASE;
  assign oor = ({1'b0, off_d} + 33'd3) >= 33'(DEPTH);
  assign hit = state_q == ACCESS && bus.byte_ack;
  assign freeze = (state_q == IDLE && mem_req) || state_q == ACCESS;
  assign MEMresult = res_q;
  assign err = err_q;
  assign bus.byte_req = req_q;
  assign bus.byte_we = bwe_q;
  assign bus.byte_addr = baddr_q;
  assign bus.byte_wdata = bwd_q;
  word_assembler u_asm (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q == IDLE && mem_req),
    .load  (hit && !bwe_q),
    .byte_i(bus.byte_rdata),
    .word_o(asm_word)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      wdat_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      bwe_q   <= 1'b0;
      baddr_q <= '0;
      bwd_q   <= '0;
    end else
      unique case (state_q)
        IDLE:
          if (mem_req) begin
            wdat_q  <= data;
            k_q     <= '0;
            state_q <= oor ? DONE : ACCESS;
            err_q   <= oor;
            req_q   <= !oor;
            if (oor && !MEMwrite) res_q <= '0;
            if (!oor) begin
              bwe_q   <= MEMwrite;
              baddr_q <= off_d;
              bwd_q   <= data[31:24];
            end
          end
        ACCESS:
          if (bus.byte_ack) begin
            k_q     <= k_q + 2'd1;
            baddr_q <= baddr_q + 32'd1;
            bwd_q   <= byte_lane(wdat_q, k_q + 2'd1);
            if (k_q == 2'd3) begin
              state_q <= DONE;
              req_q   <= 1'b0;
              if (!bwe_q) res_q <= asm_word;
            end
          end
        DONE: begin
          state_q <= IDLE;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
endmodule
